rr_burst_scheduler: RTL
=======================

# rr_burst_scheduler

Round-robin burst scheduler that shares one beat-oriented resource, such as a memory port or a DMA engine, between `PORTS` requesters. A requester asks for a burst of N beats. The scheduler grants one requester at a time, LSB-first and rotating fairly, and holds that grant until the resource has acknowledged all N beats. It then inserts one idle gap cycle and re-arbitrates. The block sits between the requester-side request vectors and the resource's beat handshake.

## Interface
- `PORTS`, 4, number of requesters (≥2)
- `LEN_W`, 8, width of each per-port burst-length field
- `MAX_BURST`, 16, upper clip on beats per grant (≥1, ≤2^LEN_W)
- `TIMEOUT`, 256, cycles without a beat ack before a forced abort; used only with the watchdog
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `request`  in  PORTS  per-port burst request level
- `req_len`  in  PORTS*LEN_W  per-port burst length minus 1; port i uses bits [i*LEN_W +: LEN_W]
- `beat_ack`  in  1  resource accepted one beat of the current burst this cycle
- `grant`  out  PORTS  one-hot grant, registered
- `grant_valid`  out  1  OR of `grant`
- `grant_encoded`  out  $clog2(PORTS)  index of the granted port
- `beats_left`  out  LEN_W  beats remaining, including the current beat
- `burst_done`  out  1  one-cycle pulse in the gap cycle after a burst ends
- `timeout`  out  1  one-cycle pulse coinciding with `burst_done` when the burst was aborted

## Operation
- States: IDLE, BURST, GAP.
- **IDLE:**
  - If `request` is nonzero, select a winner and go to BURST.
  - Latch `beats_left` = min(req_len[w]+1, MAX_BURST). Compute this in LEN_W+1 bits, with no wrap at req_len = 2^LEN_W−1.
- **Winner selection:**
  - Mask = ports with index > `last`. Pick the lowest set bit of request&mask.
  - If none, pick the lowest set bit of request.
  - `last` is updated to the winner on entry to BURST.
- **BURST:**
  - `grant`, `grant_encoded` and `grant_valid` are held.
  - Each `beat_ack` decrements `beats_left`.
  - A `beat_ack` with `beats_left`==1 moves the FSM to GAP.
- **GAP:**
  - Outputs: `grant`=0, `beats_left`=0, `burst_done`=1.
  - Next state is always IDLE.
- Request-side behaviour:
  - `request` and `req_len` are sampled only in IDLE.
  - Deasserting `request` mid-burst does not end the burst.
- `beat_ack` outside BURST is ignored.
- Reset values: all outputs 0, state IDLE, `last`=PORTS−1 (port 0 wins first).
- A reset asserted mid-burst drops `grant` immediately (asynchronously), with no `burst_done` pulse.

## Timing
- Grant latency: `request` seen high at edge n → `grant` valid after edge n+1.
- A burst of L beats with `beat_ack` tied high: `grant` is high for exactly L cycles, then 1 GAP cycle.
- Minimum re-grant spacing: 2 cycles (GAP, then IDLE) after the last ack.
  - Back-to-back bursts: grant high L cycles, low 2 cycles, high again.
- `beats_left` decrements on the edge following `beat_ack`. It is valid combinationally for the resource in the same cycle.
- `burst_done` and `timeout` are registered single-cycle pulses.

## Configuration
- Macro: `RR_BURST_SCHED_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on entry to BURST and on each `beat_ack`, and increments otherwise.
  - When the counter reaches TIMEOUT in BURST, the FSM goes to GAP and `timeout` pulses alongside `burst_done`.
  - The counter is $clog2(TIMEOUT+1) bits.
  - If `beat_ack` arrives on the same cycle the counter reaches TIMEOUT, the ack wins (normal decrement, no timeout).
- **Undefined:** no counter. `timeout` is tied 0 and a stalled burst holds grant indefinitely.

## Structure
- Shared package `rr_burst_sched_pkg`:
  - state enum `{IDLE, BURST, GAP}`
  - helper function `clip_len(len, max)`
- One sub-module, `rr_select`: combinational masked-priority pick.
  - Inputs: `request` and `last`.
  - Outputs: one-hot winner, encoded winner, and a valid flag.
- FSM, counters and registered outputs live in the top module.

## Test plan
- Reset, then request=4'b0001, req_len[0]=3, beat_ack=1 → grant=0001 for 4 cycles, burst_done pulse, beats_left sequence 4,3,2,1.
- request=4'b1111 held, all req_len=0, ack=1 → grant order 0001,0010,0100,1000,0001; each grant 1 cycle followed by 2 low cycles.
- req_len[2]=255 with MAX_BURST=16 → exactly 16 beats acked before GAP, with no 8-bit wrap.
- Mid-burst: drop request and toggle ack 1,0,1 with len 2 → grant persists until the 3rd ack; acks in IDLE/GAP do not change beats_left.
- Watchdog on, TIMEOUT=8: grant port 1, withhold ack → after 8 cycles timeout=burst_done=1 for one cycle, then port 2 is granted if requesting. With the macro off, grant stays held.
- Assert rst during beat 2 of a 5-beat burst → grant and beats_left go to 0 asynchronously. After release, port 0 wins first.

Source files
------------

// File: rtl/rr_burst_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_sched_pkg
// Purpose  : Shared types and helpers for the round-robin burst scheduler.
//            - state_t  : scheduler FSM encoding (IDLE, BURST, GAP)
//            - clip_len : converts a "length minus one" field to a beat count
//                         clipped to an upper bound
// Revision : 1.0 - initial release
// ============================================================================
package rr_burst_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Evaluated in 32 bits so len = all-ones of a narrow field cannot wrap
    // to zero when the +1 is applied.
    function automatic int unsigned clip_len(input int unsigned len,
                                             input int unsigned max);
        int unsigned beats;
        beats = len + 32'd1;
        return (beats > max) ? max : beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_burst_scheduler_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational masked-priority pick for round-robin arbitration.
//            Prefers the lowest requesting port with index above 'last';
//            falls back to the lowest requesting port overall.
// Ports    : request    - per-port request vector
//            last       - index of the most recently granted port
//            winner     - one-hot winning port
//            winner_idx - encoded winning port
//            valid      - any port requesting
// Revision : 1.0 - initial release
// ============================================================================
module rr_select
    import rr_burst_sched_pkg::*;
#(
    parameter  int PORTS   = 4,
    localparam int C_IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]   request,
    input  logic [C_IDX_W-1:0] last,
    output logic [PORTS-1:0]   winner,
    output logic [C_IDX_W-1:0] winner_idx,
    output logic               valid
);

    logic w_found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = |request;
        w_found    = 1'b0;
        // First pass: ports strictly above the previous winner.
        for (int i = 0; i < PORTS; i++) begin
            if (!w_found && request[i] && (i > int'(last))) begin
                winner[i]  = 1'b1;
                winner_idx = C_IDX_W'(i);
                w_found    = 1'b1;
            end
        end
        // Second pass: wrap around to the lowest requester.
        for (int i = 0; i < PORTS; i++) begin
            if (!w_found && request[i]) begin
                winner[i]  = 1'b1;
                winner_idx = C_IDX_W'(i);
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_scheduler
// Purpose  : Shares one beat-oriented resource between PORTS requesters.
//            Grants one port at a time (round-robin), holds the grant until
//            all beats of its burst are acknowledged, then spends one GAP
//            cycle (burst_done pulse) before re-arbitrating.
// Ports    : clk, rst (async, active-high)
//            request[PORTS], req_len[PORTS*LEN_W] (length minus one per port)
//            beat_ack        - resource accepted one beat this cycle
//            grant, grant_valid, grant_encoded - registered grant
//            beats_left      - beats remaining including the current one
//            burst_done      - pulse in the gap cycle after a burst
//            timeout         - pulse with burst_done on a watchdog abort
// Config   : `define RR_BURST_SCHED_WATCHDOG_EN enables the stall watchdog;
//            without it timeout is tied 0 and a stalled burst holds grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_scheduler
    import rr_burst_sched_pkg::*;
#(
    parameter  int PORTS     = 4,
    parameter  int LEN_W     = 8,
    parameter  int MAX_BURST = 16,
    parameter  int TIMEOUT   = 256,
    localparam int C_IDX_W   = $clog2(PORTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       request,
    input  logic [PORTS*LEN_W-1:0] req_len,
    input  logic                   beat_ack,
    output logic [PORTS-1:0]       grant,
    output logic                   grant_valid,
    output logic [C_IDX_W-1:0]     grant_encoded,
    output logic [LEN_W-1:0]       beats_left,
    output logic                   burst_done,
    output logic                   timeout
);

    if (PORTS < 2 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
        $error("rr_burst_scheduler: illegal parameter combination");
    end

    // Beat count is one bit wider than the length field so that a full
    // 2^LEN_W burst is representable.
    state_t             r_state,    w_state_nxt;
    logic [PORTS-1:0]   r_grant,    w_grant_nxt;
    logic [C_IDX_W-1:0] r_grant_idx, w_idx_nxt;
    logic [LEN_W:0]     r_beats,    w_beats_nxt;
    logic [C_IDX_W-1:0] r_last,     w_last_nxt;
    logic               r_done,     w_done_nxt;
    logic               r_timeout,  w_timeout_nxt;

    logic [PORTS-1:0]   w_sel_onehot;
    logic [C_IDX_W-1:0] w_sel_idx;
    logic               w_sel_valid;
    logic [LEN_W-1:0]   w_sel_len;
    logic [LEN_W:0]     w_clip;

`ifdef RR_BURST_SCHED_WATCHDOG_EN
    localparam int C_WD_W = $clog2(TIMEOUT + 1);
    logic [C_WD_W-1:0] r_wd_cnt, w_wd_nxt;
`endif

    rr_select #(
        .PORTS (PORTS)
    ) u_select (
        .request    (request),
        .last       (r_last),
        .winner     (w_sel_onehot),
        .winner_idx (w_sel_idx),
        .valid      (w_sel_valid)
    );

    assign w_sel_len = req_len[int'(w_sel_idx)*LEN_W +: LEN_W];
    assign w_clip    = (LEN_W+1)'(clip_len(32'(w_sel_len), MAX_BURST));

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_grant_idx;
        w_beats_nxt   = r_beats;
        w_last_nxt    = r_last;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
`ifdef RR_BURST_SCHED_WATCHDOG_EN
        w_wd_nxt      = r_wd_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_sel_onehot;
                    w_idx_nxt   = w_sel_idx;
                    w_beats_nxt = w_clip;
                    w_last_nxt  = w_sel_idx;
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                    w_wd_nxt    = '0;
`endif
                end
            end
            BURST: begin
                // An ack always takes priority over a watchdog expiry.
                if (beat_ack) begin
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                    w_wd_nxt = '0;
`endif
                    if (r_beats == (LEN_W+1)'(1)) begin
                        w_state_nxt = GAP;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
                        w_beats_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_beats_nxt = r_beats - (LEN_W+1)'(1);
                    end
                end
`ifdef RR_BURST_SCHED_WATCHDOG_EN
                // Abort on the edge where the idle count would reach TIMEOUT,
                // so grant is held for exactly TIMEOUT ack-less cycles.
                else if (r_wd_cnt == C_WD_W'(TIMEOUT - 1)) begin
                    w_state_nxt   = GAP;
                    w_grant_nxt   = '0;
                    w_idx_nxt     = '0;
                    w_beats_nxt   = '0;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wd_nxt = r_wd_cnt + C_WD_W'(1);
                end
`endif
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_beats     <= '0;
            r_last      <= C_IDX_W'(PORTS - 1);
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef RR_BURST_SCHED_WATCHDOG_EN
            r_wd_cnt    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_idx_nxt;
            r_beats     <= w_beats_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
`ifdef RR_BURST_SCHED_WATCHDOG_EN
            r_wd_cnt    <= w_wd_nxt;
`endif
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = |r_grant;
    assign grant_encoded = r_grant_idx;
    // A full 2^LEN_W count does not fit the port; it reads as all-ones.
    assign beats_left    = r_beats[LEN_W] ? {LEN_W{1'b1}} : r_beats[LEN_W-1:0];
    assign burst_done    = r_done;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire
